// File: rtl/la_wb_master_pkg.sv
// rtl/la_wb_master_pkg.sv - shared widths and FSM state type for la_wb_master
package la_wb_master_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/la_wb_timeout.sv
// rtl/la_wb_timeout.sv - saturating ack-wait counter for la_wb_master
module la_wb_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned   CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    // count holds the completed no-ack cycles, so the current cycle is the TIMEOUT-th one
    assign expired = (TIMEOUT != 0) && enable && (count >= LAST);

endmodule

// File: rtl/la_wb_master.sv
// rtl/la_wb_master.sv - single-outstanding Wishbone classic master with ack timeout
module la_wb_master
    import la_wb_master_pkg::*;
#(
    parameter int unsigned         TIMEOUT      = 255,
    parameter logic [WB_DAT_W-1:0] RSP_ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_SEL_W-1:0] cmd_sel,
    input  logic [WB_ADR_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,

    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i
);

    state_t state;
    logic   tmo_clear;
    logic   tmo_enable;
    logic   tmo_expired;

    assign tmo_clear  = (state == IDLE) && cmd_valid;
    // ack masks the timeout enable, which gives ack priority in a coincident cycle
    assign tmo_enable = (state == BUS) && !wbm_ack_i;

    la_wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= BUS;
                        cmd_ready <= 1'b0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= cmd_we;
                        wbm_sel_o <= cmd_sel;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                    end
                end
                BUS: begin
                    if (wbm_ack_i) begin
                        state     <= RESP;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                    end else if (tmo_expired) begin
                        state     <= RESP;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_dat   <= RSP_ERR_DATA;
                        rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_la_wb_master.sv
// tb/tb_la_wb_master.sv - directed self-checking bench for la_wb_master
module tb_la_wb_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_sel = '0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;

    int n_vec = 0;
    int n_err = 0;

    la_wb_master #(
        .TIMEOUT      (4),
        .RSP_ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_sel   (cmd_sel),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Issue one command from IDLE; ack_after = number of no-ack BUS cycles before ack (-1 = never)
    task automatic run_txn(input string tag, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] wdat, input int ack_after,
                           input logic [31:0] rdat, input logic [31:0] exp_dat, input logic exp_err,
                           input int exp_cycles, input bit consume);
        int cycles;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_sel   = sel;
        cmd_adr   = adr;
        cmd_dat   = wdat;
        check_vec({tag, ".rdy_idle"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check_vec({tag, ".rdy_bus"}, cmd_ready, 0);
        cycles = 0;
        while (wbm_cyc_o && cycles < 20) begin
            check_vec({tag, ".stb"}, wbm_stb_o, 1);
            check_vec({tag, ".we"}, wbm_we_o, we);
            check_vec({tag, ".sel"}, wbm_sel_o, sel);
            check_vec({tag, ".adr"}, wbm_adr_o, adr);
            check_vec({tag, ".dat_o"}, wbm_dat_o, wdat);
            check_vec({tag, ".vld_bus"}, rsp_valid, 0);
            if (cycles == ack_after) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = rdat;
            end
            cycles++;
            tick();
            wbm_ack_i = 1'b0;
        end
        check_vec({tag, ".cyc_cycles"}, cycles, exp_cycles);
        check_vec({tag, ".cyc_end"}, wbm_cyc_o, 0);
        check_vec({tag, ".stb_end"}, wbm_stb_o, 0);
        check_vec({tag, ".vld"}, rsp_valid, 1);
        check_vec({tag, ".rsp_dat"}, rsp_dat, exp_dat);
        check_vec({tag, ".rsp_err"}, rsp_err, exp_err);
        if (consume) begin
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check_vec({tag, ".vld_done"}, rsp_valid, 0);
            check_vec({tag, ".rdy_done"}, cmd_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1 wb_rst_i = 1'b1;
        #1;
        check_vec("rst.cyc", wbm_cyc_o, 0);
        check_vec("rst.stb", wbm_stb_o, 0);
        check_vec("rst.we", wbm_we_o, 0);
        check_vec("rst.sel", wbm_sel_o, 0);
        check_vec("rst.adr", wbm_adr_o, 0);
        check_vec("rst.dat", wbm_dat_o, 0);
        check_vec("rst.vld", rsp_valid, 0);
        check_vec("rst.rsp_dat", rsp_dat, 0);
        check_vec("rst.rsp_err", rsp_err, 0);
        tick();
        tick();
        wb_rst_i = 1'b0;
        tick();
        check_vec("rst.rdy", cmd_ready, 1);

        run_txn("rd", 1'b0, 4'hF, 32'h3000_0004, 32'h0, 2, 32'h1234_5678, 32'h1234_5678, 1'b0, 3, 1'b1);
        run_txn("wr", 1'b1, 4'b0011, 32'h3000_0000, 32'hA5A5_A5A5, 1, 32'hFFFF_FFFF, 32'h0, 1'b0, 2, 1'b1);
        run_txn("rd0", 1'b0, 4'hC, 32'h3000_0010, 32'h0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1, 1'b1);
        run_txn("tmo", 1'b0, 4'hF, 32'h3000_0020, 32'h0, -1, 32'h1111_1111, 32'hDEAD_BEEF, 1'b1, 4, 1'b1);
        run_txn("tmo_ack", 1'b0, 4'hF, 32'h3000_0024, 32'h0, 3, 32'h2222_2222, 32'h2222_2222, 1'b0, 4, 1'b1);

        // response backpressure with a new command waiting
        run_txn("bp", 1'b0, 4'hF, 32'h3000_0030, 32'h0, 0, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 1, 1'b0);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_sel   = 4'hF;
        cmd_adr   = 32'h3000_0034;
        cmd_dat   = 32'h0000_00AA;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_vec("bp.rdy_hold", cmd_ready, 0);
            check_vec("bp.cyc_hold", wbm_cyc_o, 0);
            check_vec("bp.vld_hold", rsp_valid, 1);
            check_vec("bp.dat_hold", rsp_dat, 32'hCAFE_0001);
            check_vec("bp.err_hold", rsp_err, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_vec("bp.vld_rel", rsp_valid, 0);
        check_vec("bp.rdy_rel", cmd_ready, 1);
        check_vec("bp.cyc_rel", wbm_cyc_o, 0);
        tick();
        cmd_valid = 1'b0;
        check_vec("bp2.cyc", wbm_cyc_o, 1);
        check_vec("bp2.we", wbm_we_o, 1);
        check_vec("bp2.adr", wbm_adr_o, 32'h3000_0034);
        check_vec("bp2.dat_o", wbm_dat_o, 32'h0000_00AA);
        check_vec("bp2.rdy", cmd_ready, 0);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        check_vec("bp2.vld", rsp_valid, 1);
        check_vec("bp2.rsp_dat", rsp_dat, 32'h0);
        check_vec("bp2.cyc_end", wbm_cyc_o, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_vec("bp2.vld_done", rsp_valid, 0);
        tick();
        check_vec("bp2.no_extra", wbm_cyc_o, 0);

        // stray acks while idle and while holding a response
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("sp_idle.cyc", wbm_cyc_o, 0);
            check_vec("sp_idle.vld", rsp_valid, 0);
            check_vec("sp_idle.rdy", cmd_ready, 1);
        end
        wbm_ack_i = 1'b0;
        run_txn("sp", 1'b0, 4'hF, 32'h3000_0040, 32'h0, 1, 32'h7777_0000, 32'h7777_0000, 1'b0, 2, 1'b0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("sp_resp.vld", rsp_valid, 1);
            check_vec("sp_resp.dat", rsp_dat, 32'h7777_0000);
            check_vec("sp_resp.err", rsp_err, 0);
            check_vec("sp_resp.cyc", wbm_cyc_o, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_vec("sp_resp.vld_done", rsp_valid, 0);
        tick();
        check_vec("sp_resp.no_extra_vld", rsp_valid, 0);
        check_vec("sp_resp.no_extra_cyc", wbm_cyc_o, 0);
        wbm_ack_i = 1'b0;

        // asynchronous reset in the middle of a bus cycle
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_sel   = 4'hF;
        cmd_adr   = 32'h3000_0050;
        cmd_dat   = 32'h0;
        tick();
        cmd_valid = 1'b0;
        tick();
        check_vec("mrst.cyc_before", wbm_cyc_o, 1);
        #2 wb_rst_i = 1'b1;
        #1;
        check_vec("mrst.cyc", wbm_cyc_o, 0);
        check_vec("mrst.stb", wbm_stb_o, 0);
        check_vec("mrst.adr", wbm_adr_o, 0);
        check_vec("mrst.vld", rsp_valid, 0);
        tick();
        wb_rst_i  = 1'b0;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h9999_9999;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_vec("mrst.vld_after", rsp_valid, 0);
            check_vec("mrst.cyc_after", wbm_cyc_o, 0);
        end
        wbm_ack_i = 1'b0;
        run_txn("post_rst", 1'b1, 4'b1000, 32'h3000_0060, 32'h0102_0304, 1, 32'hFFFF_FFFF, 32'h0, 1'b0, 2, 1'b1);
        run_txn("post_rst_tmo", 1'b0, 4'hF, 32'h3000_0064, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 1'b1, 4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/la_wb_master.md
LA_WB_MASTER -- requirements
Module: la_wb_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, max cycles awaiting wbm_ack_i before abort; 0 = wait forever.
REQ-002 SHALL have parameter: RSP_ERR_DATA, 32'hDEAD_BEEF, rsp_dat value returned on timeout.
REQ-003 SHALL have exactly one clock and an asynchronous, active-high reset; no other clock or reset input exists.
REQ-004 SHALL have port: wb_clk_i  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port: wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: cmd_valid  input  1  command offered.
REQ-007 SHALL have port: cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have ports: cmd_we  input  1  write; cmd_sel  input  4  byte lanes; cmd_adr  input  32  address; cmd_dat  input  32  write data.
REQ-009 SHALL have ports: rsp_valid  output  1  response held; rsp_ready  input  1  response consumed; rsp_dat  output  32  read data; rsp_err  output  1  timeout flag.
REQ-010 SHALL have ports: wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each; wbm_sel_o  output  4; wbm_adr_o, wbm_dat_o  output  32  Wishbone classic master outputs.
REQ-011 SHALL have ports: wbm_ack_i  input  1; wbm_dat_i  input  32  Wishbone slave responses.

Function
REQ-012 SHALL implement FSM states IDLE, BUS, RESP; reset state IDLE.
REQ-013 SHALL drive cmd_ready=1 only in IDLE; transfer captures cmd_we/sel/adr/dat and moves to BUS.
REQ-014 SHALL assert wbm_cyc_o=wbm_stb_o=1 (registered) for every BUS cycle; all wbm_*_o held stable until cycle ends.
REQ-015 SHALL, in BUS on wbm_ack_i=1: deassert cyc/stb next edge, rsp_dat=wbm_dat_i for reads or 0 for writes, rsp_err=0, go RESP.
REQ-016 SHALL count BUS cycles without ack; when count reaches TIMEOUT (TIMEOUT>0): deassert cyc/stb, rsp_dat=RSP_ERR_DATA, rsp_err=1, go RESP.
REQ-017 SHALL give ack priority over timeout when both occur in the same cycle.
REQ-018 SHALL hold rsp_valid=1 and rsp_dat/rsp_err stable throughout RESP; on rsp_ready=1 go IDLE next edge.
REQ-019 SHALL ignore wbm_ack_i outside BUS.
REQ-020 SHALL meet latency: command accepted at edge N, cyc/stb high from edge N; slave acking first BUS cycle gives rsp_valid high from edge N+1; best-case throughput one transaction per 3 cycles.
REQ-021 SHALL size the timeout counter to $clog2(TIMEOUT+1) bits, saturating, cleared on entering BUS.
REQ-022 SHALL never issue a new cycle while rsp_valid=1 (no outstanding overlap).

Reset
REQ-023 SHALL, on wb_rst_i=1, immediately force: state IDLE, cmd_ready=1 after release, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, counter=0.
REQ-024 SHALL discard any in-flight transaction and pending response on reset; no response is produced for it.

Structure
REQ-025 SHALL place state enum, WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4 in shared package la_wb_master_pkg.
REQ-026 SHALL implement the timeout counter as sub-module la_wb_timeout (inputs clear, enable; output expired).

Verification
REQ-027 SHALL cover: read adr=0x3000_0004, slave acks 2 cycles later with 0x1234_5678 -> rsp_dat=0x1234_5678, rsp_err=0, cyc high exactly 3 cycles.
REQ-028 SHALL cover: write adr=0x3000_0000 dat=0xA5A5_A5A5 sel=4'b0011 -> wbm_we_o=1, wbm_sel_o=4'b0011 stable until ack, rsp_dat=0, rsp_err=0.
REQ-029 SHALL cover: TIMEOUT=4, no ack -> cyc drops after 4 cycles, rsp_dat=0xDEAD_BEEF, rsp_err=1; ack on 4th cycle -> rsp_err=0.
REQ-030 SHALL cover: rsp_ready held low 10 cycles with cmd_valid=1 -> cmd_ready=0, no cyc, rsp stable; then one new transaction after rsp_ready.
REQ-031 SHALL cover: wb_rst_i pulsed mid-BUS -> cyc/stb low same cycle without clock edge, rsp_valid never asserts, next command completes normally.
REQ-032 SHALL cover: spurious wbm_ack_i in IDLE and RESP -> no state change, no extra response.
